ieee754_div_seq: RTL

IEEE754_DIV_SEQ -- requirements
Module: ieee754_div_seq

---
 rtl/ieee754_div_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ieee754_div_seq.sv
// Sequential single-precision divider: 25-step restoring mantissa division,
// then one normalise/pack cycle. Truncating rounding, no NaN/Inf handling.
module ieee754_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  typedef struct packed {
    logic [31:0] q;
    logic        ovf;
    logic        unf;
    logic        dbz;
  } res_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [31:0] q_q, q_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        dbz_q, dbz_d;

  logic        sign_q, sign_d;
  logic [7:0]  exp_a_q, exp_a_d;
  logic [7:0]  exp_b_q, exp_b_d;
  logic [23:0] dvs_q, dvs_d;

  logic        ge;
  logic [23:0] diff;
  res_t        res;

  // Exponent/normalisation/special-case packing; rounding is plain truncation.
  function automatic res_t pack_result(input logic s, input logic [7:0] ea,
                                       input logic [7:0] eb, input logic [24:0] qt);
    res_t              r;
    logic signed [9:0] e;
    logic [22:0]       man;
    r   = '0;
    e   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    man = qt[23:1];
    if (!qt[24]) begin
      man = qt[22:0];
      e   = e - 10'sd1;
    end
    if (eb == 8'h00) begin
      r.q   = {s, 8'hFF, 23'h0};
      r.dbz = 1'b1;
    end else if (ea == 8'h00) begin
      r.q = {s, 31'h0};
    end else if (e >= 10'sd255) begin
      r.q   = {s, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else if (e <= 10'sd0) begin
      r.q   = {s, 8'h00, 23'h0};
      r.unf = 1'b1;
    end else begin
      r.q = {s, e[7:0], man};
    end
    return r;
  endfunction

  // Remainder is always below 2*D, so the 24-bit difference is exact when ge.
  assign ge   = (rem_q >= {1'b0, dvs_q});
  assign diff = ge ? (rem_q[23:0] - dvs_q) : rem_q[23:0];
  assign res  = pack_result(sign_q, exp_a_q, exp_b_q, quo_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    sign_d  = sign_q;
    exp_a_d = exp_a_q;
    exp_b_d = exp_b_q;
    dvs_d   = dvs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIV;
          cnt_d   = 5'd0;
          rem_d   = {2'b01, a[22:0]};
          quo_d   = '0;
          sign_d  = a[31] ^ b[31];
          exp_a_d = a[30:23];
          exp_b_d = b[30:23];
          dvs_d   = {1'b1, b[22:0]};
        end
      end
      DIV: begin
        rem_d = {diff, 1'b0};
        quo_d = {quo_q[23:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        q_d     = res.q;
        ovf_d   = res.ovf;
        unf_d   = res.unf;
        dbz_d   = res.dbz;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  // Operand fields only matter while an operation is in flight.
  always_ff @(posedge clk) begin
    sign_q  <= sign_d;
    exp_a_q <= exp_a_d;
    exp_b_q <= exp_b_d;
    dvs_q   <= dvs_d;
  end

  assign q           = q_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule
